// File: rtl/snn_pkg.sv
// snn_pkg: shared defaults and FSM encoding for the spike window classifier
package snn_pkg;
   localparam int NUM_NEURONS_DEF = 8;
   localparam int CNT_W_DEF = 8;
   localparam int IDX_W_DEF = 3;
   typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, DONE} state_t;
endpackage

// File: rtl/spike_window_classifier_if.sv
// spike_window_classifier_if: inference request, spike stream and result handshake
interface spike_window_classifier_if
   import snn_pkg::*;
#(
   parameter int NUM_NEURONS = NUM_NEURONS_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int IDX_W = IDX_W_DEF
);
   logic start, spike_valid, busy, result_valid, result_ready, result_tie;
   logic [NUM_NEURONS-1:0] spike_in;
   logic [IDX_W-1:0] result_class;
   logic [CNT_W-1:0] result_count;
   modport slave (
      input start, spike_valid, spike_in, result_ready,
      output busy, result_valid, result_class, result_count, result_tie
   );
   modport master (
      output start, spike_valid, spike_in, result_ready,
      input busy, result_valid, result_class, result_count, result_tie
   );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that sticks at its maximum value
module sat_counter
   import snn_pkg::*;
#(
   parameter int W = CNT_W_DEF
) (
   input logic clk,
   input logic reset,
   input logic clr,
   input logic inc,
   output logic [W-1:0] q
);
   always_ff @(posedge clk)
      q <= (reset || clr) ? '0 : (inc && q != '1) ? q + 1'b1 : q;
endmodule

// File: rtl/spike_window_classifier.sv
// spike_window_classifier: counts spikes per neuron over a window, then reports the argmax
module spike_window_classifier
   import snn_pkg::*;
#(
   parameter int NUM_NEURONS = NUM_NEURONS_DEF,
   parameter int WINDOW = 16,
   parameter int CNT_W = CNT_W_DEF,
   parameter int IDX_W = IDX_W_DEF
) (
   input logic clk,
   input logic reset,
   spike_window_classifier_if.slave bus
);
   localparam logic [15:0] LAST_STEP = 16'(WINDOW - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
   state_t state, state_n;
   logic [15:0] step;
   logic [IDX_W-1:0] idx, nb_idx, best_idx;
   logic [CNT_W-1:0] cnt [NUM_NEURONS];
   logic [CNT_W-1:0] cur, nb_cnt, best_cnt;
   logic clr, acc, win, nb_tie, best_tie;
   assign clr = state == IDLE && bus.start;
   assign acc = state == ACCUM && bus.spike_valid;
   for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_cnt
      sat_counter #(.W(CNT_W)) u_cnt (
         .clk(clk),
         .reset(reset),
         .clr(clr),
         .inc(acc && bus.spike_in[i]),
         .q(cnt[i])
      );
   end
   // Scan step: neuron 0 seeds the best; only a strictly greater count displaces it
   assign cur = cnt[idx];
   assign win = idx == '0 || cur > best_cnt;
   assign nb_idx = win ? idx : best_idx;
   assign nb_cnt = win ? cur : best_cnt;
   assign nb_tie = !win && (best_tie || cur == best_cnt);
   always_comb begin
      state_n = state;
      case (state)
         IDLE: state_n = bus.start ? ACCUM : IDLE;
         ACCUM: state_n = (acc && step == LAST_STEP) ? ARGMAX : ACCUM;
         ARGMAX: state_n = idx == LAST_IDX ? DONE : ARGMAX;
         DONE: state_n = bus.result_ready ? IDLE : DONE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      state <= reset ? IDLE : state_n;
   always_ff @(posedge clk) begin
      if (reset) begin
         step <= '0;
         idx <= '0;
         best_idx <= '0;
         best_cnt <= '0;
         best_tie <= 1'b0;
      end else begin
         step <= clr ? '0 : acc ? step + 16'd1 : step;
         idx <= state == ARGMAX ? idx + 1'b1 : '0;
         if (state == ARGMAX) begin
            best_idx <= nb_idx;
            best_cnt <= nb_cnt;
            best_tie <= nb_tie;
         end
      end
   end
   assign bus.busy = state != IDLE;
   assign bus.result_valid = state == DONE;
   assign bus.result_class = best_idx;
   assign bus.result_count = best_cnt;
   assign bus.result_tie = best_tie;
endmodule

// File: tb/tb_spike_window_classifier.sv
// tb_spike_window_classifier: directed checks of the classifier with hand-computed results
module tb_spike_window_classifier;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   int lat;
   spike_window_classifier_if b ();
   spike_window_classifier_if #(.CNT_W(4)) s ();
   spike_window_classifier u_dut (.clk(clk), .reset(reset), .bus(b));
   spike_window_classifier #(.WINDOW(20), .CNT_W(4)) u_sat (.clk(clk), .reset(reset), .bus(s));
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask
   function automatic logic [7:0] pat(input int tst, input int k);
      return tst == 0 ? (k % 2 == 0 ? 8'h24 : 8'h20)
           : tst == 1 ? (k < 4 ? 8'h48 : 8'h00)
           : tst == 3 ? (k < 15 ? 8'h11 : 8'h10)
           : tst == 4 ? (k < 3 ? 8'h42 : 8'h40)
           : 8'h00;
   endfunction
   // Garbage spikes in the start cycle and in invalid cycles must be ignored
   task automatic run(input int tst, input int gap, input bit dbl);
      int k = 0;
      b.start = 1'b1;
      b.spike_valid = 1'b1;
      b.spike_in = 8'hFF;
      tick;
      lat = 1;
      check("busy_after_start", b.busy, 1);
      while (!b.result_valid && lat < 200) begin
         b.start = dbl && lat == 1;
         b.spike_valid = k < 16 && (lat - 1) % gap == 0;
         b.spike_in = b.spike_valid ? pat(tst, k) : 8'hFF;
         if (b.spike_valid) k++;
         tick;
         lat++;
      end
      b.start = 1'b0;
      b.spike_valid = 1'b0;
      b.spike_in = '0;
      check("result_valid", b.result_valid, 1);
   endtask
   task automatic finish_res(input logic [2:0] c, input logic [7:0] n, input logic t, input int waits);
      check("class", b.result_class, c);
      check("count", b.result_count, n);
      check("tie", b.result_tie, t);
      for (int i = 0; i < waits; i++) begin
         tick;
         check("hold_valid", b.result_valid, 1);
         check("hold_class", b.result_class, c);
         check("hold_count", b.result_count, n);
         check("hold_tie", b.result_tie, t);
      end
      b.result_ready = 1'b1;
      tick;
      b.result_ready = 1'b0;
      check("valid_cleared", b.result_valid, 0);
      check("busy_cleared", b.busy, 0);
   endtask
   initial begin
      b.start = 1'b0;
      b.spike_valid = 1'b0;
      b.spike_in = '0;
      b.result_ready = 1'b0;
      s.start = 1'b0;
      s.spike_valid = 1'b0;
      s.spike_in = '0;
      s.result_ready = 1'b0;
      repeat (3) tick;
      check("rst_busy", b.busy, 0);
      check("rst_valid", b.result_valid, 0);
      check("rst_class", b.result_class, 0);
      check("rst_count", b.result_count, 0);
      check("rst_tie", b.result_tie, 0);
      check("rst_sat_busy", s.busy, 0);
      check("rst_sat_valid", s.result_valid, 0);
      reset = 1'b0;
      tick;
      run(0, 1, 1'b0);
      check("basic_latency", lat, 25);
      finish_res(3'd5, 8'd16, 1'b0, 0);
      run(1, 1, 1'b0);
      finish_res(3'd3, 8'd4, 1'b1, 0);
      run(2, 1, 1'b0);
      finish_res(3'd0, 8'd0, 1'b1, 0);
      run(3, 3, 1'b0);
      check("gap_latency", lat, 55);
      finish_res(3'd4, 8'd16, 1'b0, 5);
      b.start = 1'b1;
      tick;
      b.start = 1'b0;
      b.spike_valid = 1'b1;
      b.spike_in = 8'hFF;
      repeat (6) tick;
      check("busy_mid_accum", b.busy, 1);
      reset = 1'b1;
      b.start = 1'b1;
      tick;
      reset = 1'b0;
      b.start = 1'b0;
      b.spike_valid = 1'b0;
      b.spike_in = '0;
      check("midrst_busy", b.busy, 0);
      check("midrst_valid", b.result_valid, 0);
      check("midrst_class", b.result_class, 0);
      check("midrst_count", b.result_count, 0);
      check("midrst_tie", b.result_tie, 0);
      run(4, 1, 1'b1);
      check("restart_latency", lat, 25);
      finish_res(3'd6, 8'd16, 1'b0, 0);
      s.start = 1'b1;
      tick;
      s.start = 1'b0;
      s.spike_valid = 1'b1;
      s.spike_in = 8'h80;
      lat = 1;
      while (!s.result_valid && lat < 200) begin
         tick;
         lat++;
      end
      s.spike_valid = 1'b0;
      s.spike_in = '0;
      check("sat_latency", lat, 29);
      check("sat_class", s.result_class, 7);
      check("sat_count", s.result_count, 15);
      check("sat_tie", s.result_tie, 0);
      s.result_ready = 1'b1;
      tick;
      s.result_ready = 1'b0;
      check("sat_valid_cleared", s.result_valid, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
